// File: rtl/maxpool_pkg.sv
// Shared constants, FSM encoding and sizing helper for the 2x2 pooling engine.
package maxpool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n distinct values; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_reduce_2x2.sv
// Two-stage registered 2x2 reduce for one channel: pair reduce, then combine.
// Inputs a,b are the top pair, c,d the bottom pair of the window.
module pool_reduce_2x2 import maxpool_pkg::*; #(
  parameter int DATA_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] res
);

  localparam int W1 = DATA_W + 1;
  localparam int W2 = DATA_W + 2;

  logic [W1-1:0]     top_q, bot_q;
  logic              mode_q;
  logic [W2-1:0]     sum2;
  logic [DATA_W-1:0] res_d;

  // Sign- or zero-extension makes a single signed compare correct for both
  // data interpretations, and keeps pair sums exact.
  function automatic logic [W1-1:0] ext1(input logic [DATA_W-1:0] v);
    return SIGNED ? {v[DATA_W-1], v} : {1'b0, v};
  endfunction

  function automatic logic [W2-1:0] ext2(input logic [W1-1:0] v);
    return SIGNED ? {v[W1-1], v} : {1'b0, v};
  endfunction

  function automatic logic [W1-1:0] pair(input logic m,
                                         input logic [DATA_W-1:0] x,
                                         input logic [DATA_W-1:0] y);
    logic [W1-1:0] ex, ey;
    ex = ext1(x);
    ey = ext1(y);
    if (m == POOL_AVG) return ex + ey;
    return ($signed(ex) >= $signed(ey)) ? ex : ey;
  endfunction

  // Stage 1: reduce top and bottom pairs, carry the mode alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q  <= '0;
      bot_q  <= '0;
      mode_q <= POOL_MAX;
    end else begin
      top_q  <= pair(mode, a, b);
      bot_q  <= pair(mode, c, d);
      mode_q <= mode;
    end
  end

  // Stage 2 combine: max of pair results, or 4-way sum with floor divide by 4.
  always_comb begin
    sum2 = ext2(top_q) + ext2(bot_q);
    if (mode_q == POOL_AVG) res_d = sum2[W2-1:2];
    else res_d = ($signed(top_q) >= $signed(bot_q)) ? top_q[DATA_W-1:0] : bot_q[DATA_W-1:0];
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res <= '0;
    else        res <= res_d;
  end

endmodule

// File: rtl/maxpool_2d.sv
// 2x2 / stride-2 max/average pooling over a whole multi-channel frame.
// One window per cycle across all channels; result frame held until taken.
module maxpool_2d import maxpool_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IN_H   = 6,
  parameter int IN_W   = 6,
  parameter int CH     = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        pool_mode,
  input  logic [CH*IN_H*IN_W*DATA_W-1:0]              in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [CH*(IN_H/2)*(IN_W/2)*DATA_W-1:0]      out_data
);

  localparam int OUT_H    = IN_H / 2;
  localparam int OUT_W    = IN_W / 2;
  localparam int N        = OUT_H * OUT_W;
  localparam int IN_BITS  = CH * IN_H * IN_W * DATA_W;
  localparam int OUT_BITS = CH * N * DATA_W;
  localparam int IDX_W    = idx_width(N);
  localparam int ROW_W    = idx_width(OUT_H);
  localparam int COL_W    = idx_width(OUT_W);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_W - 1);

  state_e                    state_q, state_d;
  logic                      rdy_q;
  logic [IN_BITS-1:0]        frame_q;
  logic                      mode_q;
  logic [ROW_W-1:0]          row_q;
  logic [COL_W-1:0]          col_q;
  logic [IDX_W-1:0]          idx_q, idx_s1, idx_s2;
  logic                      issue_done_q;
  logic [1:0]                vld_pipe;
  logic [OUT_BITS-1:0]       buf_q, buf_d;
  logic [CH-1:0][DATA_W-1:0] res;
  logic                      accept, issue, last;

  // in_ready is held low through reset and rises on the first edge after it.
  assign in_ready  = rdy_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign issue     = (state_q == ST_RUN) && !issue_done_q;
  assign last      = vld_pipe[1] && (idx_s2 == LAST_IDX);

  // Ready-enable flag out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accept -> run until last window retires -> hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Capture the frame and mode on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      mode_q  <= POOL_MAX;
    end else if (accept) begin
      frame_q <= in_data;
      mode_q  <= pool_mode;
    end
  end

  // Row-major window issue counters; row/col avoid dividing the linear index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
    end else if (accept) begin
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
    end else if (issue) begin
      idx_q <= idx_q + IDX_W'(1);
      if (col_q == LAST_COL) begin
        col_q <= '0;
        if (row_q == LAST_ROW) issue_done_q <= 1'b1;
        else                   row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Valid and window index travel alongside the two reduce stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_s1   <= '0;
      idx_s2   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      idx_s1   <= idx_q;
      idx_s2   <= idx_s1;
    end
  end

  // Per-channel window gather and reduce lane; odd trailing row/col never addressed.
  for (genvar g = 0; g < CH; g++) begin : g_lane
    logic [DATA_W-1:0] wa, wb, wc, wd;
    int                base;

    // Select the four window elements of this channel.
    always_comb begin
      base = ((g * IN_H + 2 * int'(row_q)) * IN_W + 2 * int'(col_q)) * DATA_W;
      wa   = frame_q[base +: DATA_W];
      wb   = frame_q[base + DATA_W +: DATA_W];
      wc   = frame_q[base + IN_W * DATA_W +: DATA_W];
      wd   = frame_q[base + (IN_W + 1) * DATA_W +: DATA_W];
    end

    pool_reduce_2x2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_red (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode_q),
      .a     (wa),
      .b     (wb),
      .c     (wc),
      .d     (wd),
      .res   (res[g])
    );
  end

  // Merge the retiring window into the buffer image.
  always_comb begin
    buf_d = buf_q;
    if (vld_pipe[1]) begin
      for (int c = 0; c < CH; c++)
        buf_d[(c * N + int'(idx_s2)) * DATA_W +: DATA_W] = res[c];
    end
  end

  // Buffer update; publish the full frame (including the last window) at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      out_data <= '0;
    end else begin
      buf_q <= buf_d;
      if (last) out_data <= buf_d;
    end
  end

endmodule

// File: tb/tb_maxpool_2d.sv
// Randomised self-checking bench for maxpool_2d: three configurations
// (6x6 unsigned, 6x6 signed, 4x5 two-channel unsigned) against a reference model.
module tb_maxpool_2d;

  typedef int iq_t[$];

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   iv = '0, orr = '0, pm = '0;
  logic [2:0]   ir, ov;
  logic [287:0] d0 = '0, d1 = '0;
  logic [319:0] d2 = '0;
  logic [71:0]  o0, o1;
  logic [63:0]  o2;
  int           n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  maxpool_2d #(.DATA_W(8), .IN_H(6), .IN_W(6), .CH(1), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .pool_mode(pm[0]),
    .in_data(d0), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(o0));

  maxpool_2d #(.DATA_W(8), .IN_H(6), .IN_W(6), .CH(1), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .pool_mode(pm[1]),
    .in_data(d1), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(o1));

  maxpool_2d #(.DATA_W(8), .IN_H(4), .IN_W(5), .CH(2), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .pool_mode(pm[2]),
    .in_data(d2), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(o2));

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dim_h(int k); return (k == 2) ? 4 : 6; endfunction
  function automatic int dim_w(int k); return (k == 2) ? 5 : 6; endfunction
  function automatic int dim_c(int k); return (k == 2) ? 2 : 1; endfunction
  function automatic int lat(int k);   return (dim_h(k) / 2) * (dim_w(k) / 2) + 2; endfunction

  // Reference: pool each 2x2 window straight from the element list.
  function automatic logic [319:0] model(int k, iq_t q, bit mode);
    logic [319:0] r;
    int h, w, oh, ow, s, o;
    int v[4];
    r = '0;
    h = dim_h(k); w = dim_w(k); oh = h / 2; ow = w / 2;
    for (int c = 0; c < dim_c(k); c++)
      for (int y = 0; y < oh; y++)
        for (int x = 0; x < ow; x++) begin
          v[0] = q[(c * h + 2 * y) * w + 2 * x];
          v[1] = q[(c * h + 2 * y) * w + 2 * x + 1];
          v[2] = q[(c * h + 2 * y + 1) * w + 2 * x];
          v[3] = q[(c * h + 2 * y + 1) * w + 2 * x + 1];
          if (k == 1) for (int i = 0; i < 4; i++) if (v[i] > 127) v[i] = v[i] - 256;
          if (mode) begin
            s = v[0] + v[1] + v[2] + v[3];
            o = (s - (((s % 4) + 4) % 4)) / 4;
          end else begin
            o = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > o) o = v[i];
          end
          r[((c * oh + y) * ow + x) * 8 +: 8] = 8'(o);
        end
    return r;
  endfunction

  function automatic iq_t rnd_frame(int k);
    iq_t q;
    for (int i = 0; i < dim_c(k) * dim_h(k) * dim_w(k); i++) q.push_back(int'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic iq_t zero_frame(int k);
    iq_t q;
    for (int i = 0; i < dim_c(k) * dim_h(k) * dim_w(k); i++) q.push_back(0);
    return q;
  endfunction

  function automatic logic [319:0] get_out(int k);
    logic [319:0] r;
    r = '0;
    case (k)
      0:       r[71:0] = o0;
      1:       r[71:0] = o1;
      default: r[63:0] = o2;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, iq_t q);
    for (int i = 0; i < q.size(); i++) begin
      logic [7:0] b;
      b = 8'(q[i]);
      case (k)
        0:       d0[i * 8 +: 8] = b;
        1:       d1[i * 8 +: 8] = b;
        default: d2[i * 8 +: 8] = b;
      endcase
    end
  endtask

  // Offer a frame, let it be accepted, then scramble the inputs.
  task automatic send(int k, iq_t q, bit mode);
    int b;
    b = 0;
    while (ir[k] !== 1'b1 && b < 100) begin tick(); b++; end
    chk($sformatf("ready%0d", k), ir[k], 1'b1);
    drive(k, q);
    pm[k] = mode;
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    pm[k] = ~mode;
    drive(k, rnd_frame(k));
  endtask

  task automatic wait_out(int k, string tag);
    int b;
    b = 0;
    while (ov[k] !== 1'b1 && b < 100) begin tick(); b++; end
    chk({tag, "_lat"}, b, lat(k));
  endtask

  task automatic ack(int k, string tag);
    orr[k] = 1'b1;
    tick();
    orr[k] = 1'b0;
    chk({tag, "_ovclr"}, ov[k], 1'b0);
    chk({tag, "_idle"}, ir[k], 1'b1);
  endtask

  task automatic frame(int k, iq_t q, bit mode, string tag, output logic [319:0] got);
    send(k, q, mode);
    wait_out(k, tag);
    got = get_out(k);
    chk({tag, "_data"}, got, model(k, q, mode));
    ack(k, tag);
  endtask

  initial begin
    iq_t          q, q2;
    logic [319:0] e, got;
    int           mx[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int           av[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    int           stale;

    // Reset held with in_valid asserted.
    iv = 3'b111;
    repeat (3) tick();
    chk("rst_ov", ov, 3'b000);
    chk("rst_rdy", ir, 3'b000);
    chk("rst_out0", get_out(0), '0);
    chk("rst_out2", get_out(2), '0);
    iv = '0;
    rst_n = 1'b1;
    tick();
    chk("rel_rdy", ir, 3'b111);

    // Ramp frame, max then average.
    q = {};
    for (int i = 0; i < 36; i++) q.push_back(i);
    send(0, q, 1'b0);
    wait_out(0, "ramp_max");
    e = '0;
    for (int i = 0; i < 9; i++) e[i * 8 +: 8] = 8'(mx[i]);
    chk("ramp_max_data", get_out(0), e);
    ack(0, "ramp_max");
    send(0, q, 1'b1);
    wait_out(0, "ramp_avg");
    e = '0;
    for (int i = 0; i < 9; i++) e[i * 8 +: 8] = 8'(av[i]);
    chk("ramp_avg_data", get_out(0), e);
    ack(0, "ramp_avg");

    // Backpressure with a new frame waiting.
    q = rnd_frame(0);
    send(0, q, 1'b1);
    wait_out(0, "bp");
    e = model(0, q, 1'b1);
    chk("bp_data", get_out(0), e);
    q2 = rnd_frame(0);
    drive(0, q2);
    pm[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_ov", ov[0], 1'b1);
      chk("bp_hold", get_out(0), e);
      chk("bp_rdy", ir[0], 1'b0);
    end
    orr[0] = 1'b1;
    tick();
    orr[0] = 1'b0;
    chk("bp_ovclr", ov[0], 1'b0);
    chk("bp_idle", ir[0], 1'b1);
    chk("bp_retain", get_out(0), e);
    tick();
    iv[0] = 1'b0;
    pm[0] = 1'b1;
    drive(0, rnd_frame(0));
    wait_out(0, "bp2");
    chk("bp2_data", get_out(0), model(0, q2, 1'b0));
    ack(0, "bp2");

    // Signedness on the first window.
    q = zero_frame(0);
    q[0] = 'h80; q[1] = 'h01; q[6] = 'h02; q[7] = 'h03;
    frame(1, q, 1'b0, "s_max", got);
    chk("s_max_byte", got[7:0], 8'h03);
    frame(0, q, 1'b0, "u_max", got);
    chk("u_max_byte", got[7:0], 8'h80);
    q[0] = 'h80; q[1] = 'hFF; q[6] = 'hFB; q[7] = 'hFD;
    frame(1, q, 1'b1, "s_avg", got);
    chk("s_avg_byte", got[7:0], 8'hDD);

    // Reset in the middle of a run.
    send(2, rnd_frame(2), 1'b0);
    send(0, rnd_frame(0), 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov, 3'b000);
    chk("mid_rst_rdy", ir, 3'b000);
    chk("mid_rst_out2", get_out(2), '0);
    tick();
    rst_n = 1'b1;
    stale = 0;
    repeat (20) begin
      tick();
      if (ov !== 3'b000) stale++;
    end
    chk("no_stale", stale, 0);
    q = rnd_frame(2);
    frame(2, q, 1'b0, "ch2_max", got);
    frame(2, q, 1'b1, "ch2_avg", got);

    // Random frames across all configurations.
    for (int n = 0; n < 8; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      frame(k, rnd_frame(k), bit'($urandom_range(0, 1)), $sformatf("rnd%0d_k%0d", n, k), got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
